// File: rtl/hilo_ctrl_if.sv
// HI/LO controller bus: operation handshake, unit results, MTHI/MTLO and architectural HI/LO.
// slave is the controller's view; master is the control unit / datapath view.
interface hilo_ctrl_if;
  logic        op_start;
  logic        op_sel;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_exc;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  op_start, op_sel, mult_hi, mult_lo, div_hi, div_lo, div_exc, mthi, mtlo, wdata,
    output busy, done, div_zero, hi, lo
  );

  modport master (
    output op_start, op_sel, mult_hi, mult_lo, div_hi, div_lo, div_exc, mthi, mtlo, wdata,
    input  busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/hilo_ctrl.sv
// Sequences one multiply/divide at a time, waits a fixed latency, then commits the
// selected unit's HI/LO results. Also serves MTHI/MTLO writes and flags divide-by-zero.
module hilo_ctrl #(
  parameter int unsigned MULT_CYCLES = 1,
  parameter int unsigned DIV_CYCLES  = 1
) (
  input logic        clk,
  input logic        reset,
  hilo_ctrl_if.slave bus
);

  localparam logic [5:0] MultLat = 6'(MULT_CYCLES);
  localparam logic [5:0] DivLat  = 6'(DIV_CYCLES);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_sel_q, op_sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_sel_d   = op_sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      StIdle: begin
        // A starting operation swallows any MTHI/MTLO presented in the same cycle.
        if (bus.op_start) begin
          op_sel_d = bus.op_sel;
          cnt_d    = bus.op_sel ? DivLat : MultLat;
          busy_d   = 1'b1;
          state_d  = StWait;
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      StWait: begin
        if (cnt_q > 6'd1) begin
          cnt_d = cnt_q - 6'd1;
        end else begin
          if (!op_sel_q) begin
            hi_d = bus.mult_hi;
            lo_d = bus.mult_lo;
          end else if (!bus.div_exc) begin
            hi_d = bus.div_hi;
            lo_d = bus.div_lo;
          end else begin
            div_zero_d = 1'b1;
          end
          cnt_d   = 6'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 6'd0;
      op_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_sel_q   <= op_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl (MULT_CYCLES=4, DIV_CYCLES=1): a per-cycle vector table
// followed by hand-written reset-mid-operation and busy-length sequences.
module tb_hilo_ctrl;

  logic clk;
  logic reset;
  hilo_ctrl_if bus ();

  hilo_ctrl #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op_start;
    logic        op_sel;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_exc;
    logic        e_busy;
    logic        e_done;
    logic        e_dz;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic st, logic sel, logic wh, logic wl, logic [31:0] wd,
                              logic [31:0] mh, logic [31:0] ml, logic [31:0] dh,
                              logic [31:0] dl, logic dx, logic b, logic d, logic z,
                              logic [31:0] h, logic [31:0] l);
    vec_t v;
    v.op_start = st; v.op_sel = sel; v.mthi = wh; v.mtlo = wl; v.wdata = wd;
    v.mult_hi = mh; v.mult_lo = ml; v.div_hi = dh; v.div_lo = dl; v.div_exc = dx;
    v.e_busy = b; v.e_done = d; v.e_dz = z; v.e_hi = h; v.e_lo = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic b, input logic d, input logic z,
                           input logic [31:0] h, input logic [31:0] l);
    check({tag, " busy"}, 32'(bus.busy), 32'(b));
    check({tag, " done"}, 32'(bus.done), 32'(d));
    check({tag, " div_zero"}, 32'(bus.div_zero), 32'(z));
    check({tag, " hi"}, bus.hi, h);
    check({tag, " lo"}, bus.lo, l);
  endtask

  task automatic idle_inputs();
    bus.op_start = 0; bus.op_sel = 0; bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;
    bus.mult_hi = 0; bus.mult_lo = 0; bus.div_hi = 0; bus.div_lo = 0; bus.div_exc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] Junk = 32'h5555_5555;
  localparam logic [31:0] Hp   = 32'hAAAA_0000;
  localparam logic [31:0] Lp   = 32'h0000_BBBB;

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_all("in_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check_all("after_reset", 0, 0, 0, 0, 0);

    // Each row: inputs held over one edge, then the outputs expected after that edge.
    // MTHI and MTLO preload
    vecs.push_back(mk(0, 0, 1, 0, Hp, Junk, Junk, Junk, Junk, 0, 0, 0, 0, Hp, 0));
    vecs.push_back(mk(0, 0, 0, 1, Lp, Junk, Junk, Junk, Junk, 0, 0, 0, 0, Hp, Lp));
    // Divide by zero: start, then commit edge with div_exc
    vecs.push_back(mk(1, 1, 0, 0, 0, Junk, Junk, Junk, Junk, 1, 1, 0, 0, Hp, Lp));
    vecs.push_back(mk(0, 0, 0, 0, 0, Junk, Junk, Junk, Junk, 1, 0, 1, 1, Hp, Lp));
    vecs.push_back(mk(0, 0, 0, 0, 0, Junk, Junk, Junk, Junk, 0, 0, 0, 0, Hp, Lp));
    // Divide started alongside MTHI: the write must be dropped
    vecs.push_back(mk(1, 1, 1, 0, 32'h1234_5678, Junk, Junk, Junk, Junk, 0, 1, 0, 0, Hp, Lp));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h9999_9999, 32'h9999_9999, 1, 14, 0, 0, 1, 0, 1, 14));
    // Multiply accepted in the done cycle; op_start/MTHI/MTLO during WAIT are ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, Junk, Junk, Junk, Junk, 0, 1, 0, 0, 1, 14));
    vecs.push_back(mk(1, 1, 1, 0, 32'hDEAD_BEEF, Junk, Junk, Junk, Junk, 0, 1, 0, 0, 1, 14));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, Junk, Junk, Junk, Junk, 0, 1, 0, 0, 1, 14));
    vecs.push_back(mk(1, 0, 0, 0, 0, Junk, Junk, Junk, Junk, 0, 1, 0, 0, 1, 14));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, Junk, Junk, 1, 0, 1, 0, 1, 32'hFFFF_FFFE));
    vecs.push_back(mk(0, 0, 0, 0, 0, Junk, Junk, Junk, Junk, 0, 0, 0, 0, 1, 32'hFFFF_FFFE));
    vecs.push_back(mk(0, 0, 0, 0, 0, Junk, Junk, Junk, Junk, 0, 0, 0, 0, 1, 32'hFFFF_FFFE));

    foreach (vecs[i]) begin
      bus.op_start = vecs[i].op_start; bus.op_sel = vecs[i].op_sel;
      bus.mthi = vecs[i].mthi; bus.mtlo = vecs[i].mtlo; bus.wdata = vecs[i].wdata;
      bus.mult_hi = vecs[i].mult_hi; bus.mult_lo = vecs[i].mult_lo;
      bus.div_hi = vecs[i].div_hi; bus.div_lo = vecs[i].div_lo; bus.div_exc = vecs[i].div_exc;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done, vecs[i].e_dz,
                vecs[i].e_hi, vecs[i].e_lo);
    end
    idle_inputs();

    // Reset at the second WAIT edge of a multiply: dropped with no done pulse
    bus.op_start = 1;
    tick();
    bus.op_start = 0;
    check_all("rst_mid_e0", 1, 0, 0, 1, 32'hFFFF_FFFE);
    tick();
    reset = 1'b1;
    bus.mult_hi = Junk; bus.mult_lo = Junk;
    tick();
    reset = 1'b0;
    check_all("rst_mid_e2", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all($sformatf("rst_mid_after%0d", i), 0, 0, 0, 0, 0);
    end
    idle_inputs();

    // Busy length of a fresh multiply, bounded wait for done
    begin
      int busy_cycles = 0;
      bit seen_done = 0;
      bus.op_start = 1;
      bus.mult_hi = 32'h0000_00C3;
      bus.mult_lo = 32'h0000_003C;
      tick();
      bus.op_start = 0;
      for (int i = 0; i < 20 && !seen_done; i++) begin
        if (bus.busy) busy_cycles++;
        if (bus.done) seen_done = 1;
        else tick();
      end
      check("mult_done_seen", 32'(seen_done), 32'd1);
      check("mult_busy_cycles", 32'(busy_cycles), 32'd4);
      check("mult_hi_commit", bus.hi, 32'h0000_00C3);
      check("mult_lo_commit", bus.lo, 32'h0000_003C);
      tick();
      check("mult_done_clear", 32'(bus.done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
